count_tracker: RTL

Receive-side companion to the 6-bit up/down counter. Samples a 6-bit count stream each qualified cycle, decodes the stepping direction using the counter's encoding (0 = +1, 1 = −1), reports lock status, and flags illegal steps. It sits downstream of the counter in lab datapaths as a self-checking monitor and direction decoder.

---
 rtl/count_tracker.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/count_tracker.sv
// ---------------------------------------------------------------------------
// count_tracker
//
// Receive-side monitor for the 6-bit up/down counter. Each qualified cycle
// the observed count is compared with the previous qualified count. The
// step is classified as UP (+1 mod 64), DOWN (-1 mod 64) or BAD. From that
// the block decodes the counting direction, tracks lock, and flags illegal
// steps and legal reversals.
//
// Optional feature macro: COUNT_TRACKER_WRAP_STAT_EN
//   defined   : wrap_count counts (saturating) 63->0 / 0->63 wraps seen
//               while locked.
//   undefined : wrap_count is tied to 0. There is no wrap register.
//
// Ports
//   CLK        in   1  rising-edge clock
//   reset      in   1  synchronous, active-high reset
//   din        in   6  count value under observation
//   valid      in   1  din qualifier; when low the sample is ignored
//   direction  out  1  0 = counting up, 1 = counting down
//   locked     out  1  high while in LOCK_UP or LOCK_DOWN
//   step_err   out  1  one-cycle pulse: illegal step while locked
//   dir_change out  1  one-cycle pulse: legal reversal while locked
//   err_count  out  8  saturating count of step_err events
//   wrap_count out  8  saturating count of wraps (0 unless macro defined)
// ---------------------------------------------------------------------------
module count_tracker (
    input  logic       CLK,
    input  logic       reset,
    input  logic [5:0] din,
    input  logic       valid,
    output logic       direction,
    output logic       locked,
    output logic       step_err,
    output logic       dir_change,
    output logic [7:0] err_count,
    output logic [7:0] wrap_count
);

    typedef enum logic [1:0] {
        UNSYNC    = 2'd0,
        ACQUIRE   = 2'd1,
        LOCK_UP   = 2'd2,
        LOCK_DOWN = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] prev_q, prev_d;
    logic       dir_q, dir_d;
    logic       step_err_q, step_err_d;
    logic       dir_change_q, dir_change_d;
    logic [7:0] err_count_q, err_count_d;

    // Step classification. The 6-bit subtraction wraps, so 63->0 is UP
    // and 0->63 is DOWN with no special casing.
    logic [5:0] delta;
    logic       step_up, step_dn;

    assign delta   = din - prev_q;
    assign step_up = (delta == 6'd1);
    assign step_dn = (delta == 6'd63);

    // ---------------- state register ----------------
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // register samples the pre-edge values of the others.
        if (reset) begin
            state_q      <= UNSYNC;
            prev_q       <= '0;
            dir_q        <= 1'b0;
            step_err_q   <= 1'b0;
            dir_change_q <= 1'b0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            dir_q        <= dir_d;
            step_err_q   <= step_err_d;
            dir_change_q <= dir_change_d;
            err_count_q  <= err_count_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        // NOTE: default first so every path assigns state_d (no latch).
        state_d = state_q;
        if (valid) begin
            unique case (state_q)
                UNSYNC:    state_d = ACQUIRE;
                ACQUIRE:   if (step_up)      state_d = LOCK_UP;
                           else if (step_dn) state_d = LOCK_DOWN;
                LOCK_UP:   if (step_dn)      state_d = LOCK_DOWN;
                           else if (!step_up) state_d = ACQUIRE;
                LOCK_DOWN: if (step_up)      state_d = LOCK_UP;
                           else if (!step_dn) state_d = ACQUIRE;
                default:   state_d = UNSYNC;
            endcase
        end
    end

    // ---------------- output / datapath logic ----------------
    always_comb begin
        prev_d       = valid ? din : prev_q;
        dir_d        = dir_q;
        step_err_d   = 1'b0;
        dir_change_d = 1'b0;
        err_count_d  = err_count_q;
        if (valid) begin
            unique case (state_q)
                ACQUIRE: begin
                    if (step_up)      dir_d = 1'b0;
                    else if (step_dn) dir_d = 1'b1;
                end
                LOCK_UP, LOCK_DOWN: begin
                    if (step_up || step_dn) begin
                        dir_d = step_dn;
                        // A reversal is a legal step against the locked sense.
                        dir_change_d = (state_q == LOCK_UP) ? step_dn : step_up;
                    end else begin
                        step_err_d  = 1'b1;
                        err_count_d = (err_count_q == 8'hFF) ? err_count_q
                                                             : err_count_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign direction  = dir_q;
    assign locked     = (state_q == LOCK_UP) || (state_q == LOCK_DOWN);
    assign step_err   = step_err_q;
    assign dir_change = dir_change_q;
    assign err_count  = err_count_q;

`ifdef COUNT_TRACKER_WRAP_STAT_EN
    logic [7:0] wrap_count_q, wrap_count_d;
    logic       wrap_hit;

    // Only 63->0 and 0->63 qualify, and both are legal steps by construction.
    // Wraps seen while acquiring are not counted.
    assign wrap_hit = valid && locked &&
                      (((prev_q == 6'd63) && (din == 6'd0)) ||
                       ((prev_q == 6'd0)  && (din == 6'd63)));

    always_comb begin
        wrap_count_d = wrap_count_q;
        if (wrap_hit && (wrap_count_q != 8'hFF))
            wrap_count_d = wrap_count_q + 8'd1;
    end

    always_ff @(posedge CLK) begin
        if (reset) wrap_count_q <= '0;
        else       wrap_count_q <= wrap_count_d;
    end

    assign wrap_count = wrap_count_q;
`else
    assign wrap_count = 8'd0;
`endif

endmodule
